seg7_card_decoder: RTL
======================

SEG7_CARD_DECODER -- requirements
Module: seg7_card_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 3, range 1..15: the number of consecutive identical accepted samples required before a decode.
REQ-002 SHALL have port slow_clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port seg_in  input  7  active-low segment pattern, bit order {g,f,e,d,c,b,a}.
REQ-005 SHALL have port seg_valid  input  1  seg_in holds a sample this cycle.
REQ-006 SHALL have port seg_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port card_out  output  4  decoded card value, 0=blank, 1=A, 2..10, 11=J, 12=Q, 13=K.
REQ-008 SHALL have port card_valid  output  1  card_out holds a valid decode.
REQ-009 SHALL have port out_ready  input  1  consumer takes card_out this cycle.
REQ-010 SHALL have port decode_err  output  1  one-cycle pulse: the qualified pattern was illegal.
REQ-011 SHALL have port err_count  output  8  saturating count of illegal qualified patterns.

Function
REQ-012 SHALL transfer a sample only on a cycle where seg_valid=1 and seg_ready=1.
REQ-013 SHALL decode the patterns 1111111->0, 0001000->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 1000000->10, 1100001->11, 0011000->12, 0001001->13; every other pattern is illegal.
REQ-014 SHALL implement the states IDLE, QUALIFY, DECODE and OUT.
REQ-015 IDLE: seg_ready=1; on a transfer, capture seg_in as the candidate with count=1, then go to DECODE if STABLE_CYCLES=1, else to QUALIFY.
REQ-016 QUALIFY: seg_ready=1.
- Transfer equal to candidate: count+1; go to DECODE when count reaches STABLE_CYCLES.
- Transfer differing from candidate: recapture the candidate, count=1, stay in QUALIFY.
- No transfer: candidate and count hold.
REQ-017 DECODE: lasts exactly one cycle with seg_ready=0.
- Legal candidate: load card_out, go to OUT.
- Illegal candidate: pulse decode_err for that one cycle, increment err_count (saturating at 255), go to IDLE; card_out is unchanged.
REQ-018 OUT: card_valid=1, seg_ready=0, card_out stable; on out_ready=1 go to IDLE with card_valid=0 on the next cycle.
REQ-019 With STABLE_CYCLES=3, SHALL raise card_valid exactly 2 cycles after the third consecutive identical transfer (1 cycle in DECODE, then OUT).
REQ-020 SHALL ignore seg_in and seg_valid in DECODE and OUT; no sample is buffered.
REQ-021 card_out SHALL retain the last legal decode after the OUT handshake until the next legal decode.
REQ-022 SHALL ignore out_ready outside OUT.

Reset
REQ-023 While reset=1, SHALL force the following asynchronously: state=IDLE, candidate=0, count=0, card_out=0, card_valid=0, decode_err=0, err_count=0, seg_ready=0.
REQ-024 seg_ready SHALL rise in the first cycle after reset deasserts.
REQ-025 Reset asserted mid-operation, in any state, SHALL discard the candidate and any pending output; no decode_err or card_valid is emitted.

Configuration
REQ-026 With macro SEG7_ERR_COUNT_EN defined, err_count SHALL behave per REQ-017.
REQ-027 Without SEG7_ERR_COUNT_EN, the err_count port SHALL remain and be tied to 0, and no counter register is built; decode_err still pulses.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Scenario 1, legal decode: STABLE_CYCLES=3, three consecutive transfers of 0100100 -> card_valid=1 with card_out=2 two cycles after the third transfer; held until out_ready=1.
- Scenario 2, requalification: transfers 0001001, 0001001, 0011000, 0011000, 0011000 -> a single output card_out=12; no output for 13.
- Scenario 3, illegal pattern: three transfers of 1010101 -> one-cycle decode_err; err_count 0->1; card_valid stays 0; return to IDLE with seg_ready=1.
- Scenario 4, err_count saturation: 260 illegal qualifications -> err_count=255 with SEG7_ERR_COUNT_EN defined; 0 without it.
- Scenario 5, backpressure and reset: with out_ready held 0, card_out=7 stays valid and seg_ready=0 for 10 cycles; reset pulsed -> card_valid=0, card_out=0, seg_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/seg7_card_decoder.sv
// seg7_card_decoder: qualifies an active-low 7-segment pattern {g,f,e,d,c,b,a}.
// A pattern must be seen STABLE_CYCLES times in a row before it is decoded
// into a card value (0=blank, 1=A, 2..10, 11=J, 12=Q, 13=K).
// Illegal patterns produce a one-cycle decode_err pulse.
// Optional feature macro: SEG7_ERR_COUNT_EN builds the saturating err_count
// register. Without it, err_count is tied to zero.
module seg7_card_decoder #(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic       seg_ready,
  output logic [3:0] card_out,
  output logic       card_valid,
  input  logic       out_ready,
  output logic       decode_err,
  output logic [7:0] err_count
);

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, QUALIFY, DECODE, OUT} state_t;

  state_t     state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [3:0] count_q, count_d;
  logic [3:0] count_inc;
  logic       ready_q;
  logic       card_valid_q;
  logic       decode_err_q;
  logic [3:0] card_q;
  logic       xfer;

  // Returns 1 when the pattern is one of the fourteen displayable cards.
  function automatic logic pattern_legal(input logic [6:0] p);
    case (p)
      7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
      7'b1000000, 7'b1100001, 7'b0011000, 7'b0001001: pattern_legal = 1'b1;
      default:                                         pattern_legal = 1'b0;
    endcase
  endfunction

  // Card value for a legal pattern; illegal patterns map to 0 but are never loaded.
  function automatic logic [3:0] decode_value(input logic [6:0] p);
    case (p)
      7'b0001000: decode_value = 4'd1;
      7'b0100100: decode_value = 4'd2;
      7'b0110000: decode_value = 4'd3;
      7'b0011001: decode_value = 4'd4;
      7'b0010010: decode_value = 4'd5;
      7'b0000010: decode_value = 4'd6;
      7'b1111000: decode_value = 4'd7;
      7'b0000000: decode_value = 4'd8;
      7'b0010000: decode_value = 4'd9;
      7'b1000000: decode_value = 4'd10;
      7'b1100001: decode_value = 4'd11;
      7'b0011000: decode_value = 4'd12;
      7'b0001001: decode_value = 4'd13;
      default:    decode_value = 4'd0;
    endcase
  endfunction

  // ready_q is only ever high in IDLE/QUALIFY, so a transfer implies one of those states.
  assign xfer      = seg_valid & ready_q;
  assign count_inc = count_q + 4'd1;

  // Next-state logic: candidate capture, run-length counting and state transitions.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          cand_d  = seg_in;
          count_d = 4'd1;
          state_d = (STABLE_C == 4'd1) ? DECODE : QUALIFY;
        end
      end
      QUALIFY: begin
        if (xfer) begin
          if (seg_in == cand_q) begin
            count_d = count_inc;
            if (count_inc == STABLE_C) state_d = DECODE;
          end else begin
            cand_d  = seg_in;
            count_d = 4'd1;
          end
        end
      end
      DECODE: begin
        state_d = pattern_legal(cand_q) ? OUT : IDLE;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  // FSM and registered outputs; outputs are derived from the next state so
  // they line up with the state they describe.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cand_q       <= 7'd0;
      count_q      <= 4'd0;
      ready_q      <= 1'b0;
      card_valid_q <= 1'b0;
      decode_err_q <= 1'b0;
      card_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      count_q      <= count_d;
      ready_q      <= (state_d == IDLE) || (state_d == QUALIFY);
      card_valid_q <= (state_d == OUT);
      decode_err_q <= (state_d == DECODE) && !pattern_legal(cand_d);
      if (state_q == DECODE && pattern_legal(cand_q)) card_q <= decode_value(cand_q);
    end
  end

  assign seg_ready  = ready_q;
  assign card_valid = card_valid_q;
  assign decode_err = decode_err_q;
  assign card_out   = card_q;

`ifdef SEG7_ERR_COUNT_EN
  logic [7:0] err_count_q;

  // Saturating count of illegal patterns, bumped as the DECODE cycle ends.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      err_count_q <= 8'd0;
    end else if (state_q == DECODE && !pattern_legal(cand_q) && err_count_q != 8'hFF) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule
